multicycle_seq: RTL and testbench
=================================

// Module: multicycle_seq
// PURPOSE
//   Multi-cycle phase sequencer for the miniLA core: steps each instruction through IF/ID/EX/MEM/WB.
//   Consumes instruction-class flags from the instruction decoder.
//   Drives the state-element write enables and the IROM/DRAM request handshakes.
//   Lets the decoder/ALU/NPC datapath run from variable-latency memories instead of single-cycle ones.
// PARAMETERS
//   CNT_W        32   width of retired-instruction counter inst_cnt
//   MEM_TIMEOUT  15   max cycles a req may wait for ack before bus error (>=1)
// PORTS
//   cpu_clk    in   1      system clock; all state on rising edge
//   cpu_rst    in   1      synchronous, active-high reset
//   run        in   1      1 = keep fetching; 0 = park in IF after current instruction retires
//   is_load    in   1      decoded LD.B/BU/H/HU/W
//   is_store   in   1      decoded ST.B/H/W
//   is_branch  in   1      decoded BEQ/BNE/BLT/BLTU/BGE/BGEU/B (no register write)
//   wb_ena     in   1      decoder write-back enable
//   irom_ack   in   1      IROM data valid this cycle
//   dram_ack   in   1      DRAM access done / read data valid this cycle
//   irom_req   out  1      instruction fetch request
//   ir_we      out  1      latch IROM data into IR
//   dram_req   out  1      DRAM access request
//   dram_we    out  1      DRAM request is a write
//   rf_we      out  1      register file write strobe
//   pc_we      out  1      commit NPC into PC
//   commit     out  1      1-cycle pulse per retired instruction
//   state      out  3      current phase (debug LEDs)
//   inst_cnt   out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//   bus_err    out  1      sticky: a request timed out
// BEHAVIOUR
//   Reset:
//   - state=IF; inst_cnt=0; bus_err=0; wait counter=0.
//   - All strobes/reqs are 0 in the reset cycle.
//   - Reset mid-MEM abandons the access with no commit.
//   Outputs:
//   - irom_req, dram_req and dram_we are Moore outputs of state.
//   - ir_we, pc_we, rf_we and commit are combinational from state and ack.
//   - Decoder flags are sampled only in EX/MEM/WB, when IR is stable.
//   - If is_load and is_store are both set, is_load wins.
//   IF: irom_req = run & ~bus_err.
//   - On ack: ir_we=1, ->ID.
//   - run=0: no req, hold IF.
//   ID: ->EX, 1 cycle.
//   EX:
//   - load|store ->MEM.
//   - is_branch | ~wb_ena: pc_we=1, commit=1, ->IF.
//   - else ->WB (ALU ops, LU12I, PCADDU, BL, JIRL).
//   MEM: dram_req=1, dram_we=is_store & ~is_load.
//   - On dram_ack, store: pc_we=1, commit=1, ->IF.
//   - On dram_ack, load: ->WB.
//   WB: rf_we=wb_ena, pc_we=1, commit=1, ->IF.
//   Latency: 4 cycles for ALU ops, 3 for branches, 4 for stores and 5 for loads when every ack is same-cycle.
//   Wait counter:
//   - Counts consecutive IF/MEM cycles with req=1 and ack=0; clears on ack or on state change.
//   - When it reaches MEM_TIMEOUT with no ack that cycle: bus_err<=1, ->IF, no commit.
//   - ack in the same cycle as timeout: ack wins.
//   - After timeout, FSM stays parked in IF until cpu_rst.
//   run falling mid-instruction: the instruction completes; no new irom_req.
//   inst_cnt += 1 on each commit; all-ones wraps to 0.
// STRUCTURE
//   Shared header multicycle_defs.vh holds:
//   - `ST_IF=3'd0, `ST_ID=3'd1, `ST_EX=3'd2, `ST_MEM=3'd3, `ST_WB=3'd4.
//   Single module, no sub-modules. Wait counter width = $clog2(MEM_TIMEOUT+1).
//   Top level ORs is_branch from the decoder's branch/B group and gates the datapath's wb_ena with rf_we.
// TESTING
//   ADDI.W, acks same-cycle: ir_we c1; rf_we+pc_we+commit c4; inst_cnt 0->1; 4 cycles/inst.
//   ST.W, dram_ack after 2 waits: dram_req=dram_we=1 for 3 cycles; pc_we+commit on ack; rf_we never 1.
//   LD.W, immediate ack: MEM->WB; rf_we=1 and pc_we=1 both in the WB cycle; 5 cycles total.
//   BEQ: pc_we+commit in EX (c3), no MEM, no rf_we; next irom_req on c4.
//   MEM_TIMEOUT=4, irom_ack held 0: bus_err=1 after 4 req cycles; irom_req=0 afterwards; inst_cnt unchanged.
//   run=0 asserted during MEM / cpu_rst asserted during MEM:
//   - run=0: instruction retires, then FSM parks in IF.
//   - cpu_rst: next cycle state=IF, outputs 0, inst_cnt=0.

Source files
------------

// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the miniLA multi-cycle phase sequencer.
//   state_e : instruction phase encoding. The values are visible on the debug LEDs,
//             so they must stay fixed: IF=0, ID=1, EX=2, MEM=3, WB=4.
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

endpackage

// File: rtl/multicycle_seq.sv
// Multi-cycle phase sequencer: steps each instruction through IF/ID/EX/MEM/WB and
// handshakes with variable-latency IROM/DRAM.
// Ports:
//   cpu_clk, cpu_rst           clock; synchronous active-high reset
//   run                        keep fetching (0 = park in IF after current instruction)
//   is_load/is_store/is_branch instruction class flags from the decoder
//   wb_ena                     decoder write-back enable
//   irom_ack, dram_ack         memory acknowledges
//   irom_req, ir_we            fetch request / latch IR
//   dram_req, dram_we          data access request / request is a write
//   rf_we, pc_we, commit       register write, PC commit, retire pulse
//   state                      current phase (debug)
//   inst_cnt                   retired-instruction counter (wraps)
//   bus_err                    sticky request-timeout flag
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             run,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             wb_ena,
    input  logic             irom_ack,
    input  logic             dram_ack,
    output logic             irom_req,
    output logic             ir_we,
    output logic             dram_req,
    output logic             dram_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             commit,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_cnt,
    output logic             bus_err
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    state_e             r_state;
    state_e             w_state_d;
    logic [WaitW-1:0]   r_wait;
    logic [WaitW-1:0]   w_wait_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_err;

    logic w_irom_req, w_ir_we, w_dram_req, w_dram_we;
    logic w_rf_we, w_pc_we, w_commit;
    logic w_waiting, w_timeout;

    always_comb begin
        w_state_d  = r_state;
        w_irom_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dram_req = 1'b0;
        w_dram_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_commit   = 1'b0;
        w_waiting  = 1'b0;
        w_timeout  = 1'b0;
        w_wait_d   = '0;

        unique case (r_state)
            StIf: begin
                w_irom_req = run & ~r_bus_err;
                if (w_irom_req && irom_ack) begin
                    w_ir_we   = 1'b1;
                    w_state_d = StId;
                end
            end
            StId: w_state_d = StEx;
            StEx: begin
                if (is_load || is_store) begin
                    w_state_d = StMem;
                end else if (is_branch || !wb_ena) begin
                    w_pc_we   = 1'b1;
                    w_commit  = 1'b1;
                    w_state_d = StIf;
                end else begin
                    w_state_d = StWb;
                end
            end
            StMem: begin
                w_dram_req = 1'b1;
                // Both flags set decodes as a load.
                w_dram_we  = is_store & ~is_load;
                if (dram_ack) begin
                    if (is_load) begin
                        w_state_d = StWb;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_commit  = 1'b1;
                        w_state_d = StIf;
                    end
                end
            end
            StWb: begin
                w_rf_we   = wb_ena;
                w_pc_we   = 1'b1;
                w_commit  = 1'b1;
                w_state_d = StIf;
            end
            default: w_state_d = StIf;
        endcase

        // An ack in the timeout cycle wins because w_waiting requires ack=0.
        w_waiting = (w_irom_req & ~irom_ack) | (w_dram_req & ~dram_ack);
        w_timeout = w_waiting && (r_wait == WaitLast);
        if (w_timeout) begin
            w_state_d = StIf;
        end
        // A stall never changes state, so any non-stall cycle restarts the count.
        if (w_waiting && !w_timeout) begin
            w_wait_d = r_wait + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state   <= StIf;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            if (w_commit) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Strobes are forced low during the reset cycle so an abandoned access cannot commit.
    assign irom_req = w_irom_req & ~cpu_rst;
    assign ir_we    = w_ir_we    & ~cpu_rst;
    assign dram_req = w_dram_req & ~cpu_rst;
    assign dram_we  = w_dram_we  & ~cpu_rst;
    assign rf_we    = w_rf_we    & ~cpu_rst;
    assign pc_we    = w_pc_we    & ~cpu_rst;
    assign commit   = w_commit   & ~cpu_rst;
    assign state    = r_state;
    assign inst_cnt = r_cnt;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_multicycle_seq.sv
module tb_multicycle_seq;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;

    logic             cpu_clk = 1'b0;
    logic             cpu_rst, run, is_load, is_store, is_branch, wb_ena, irom_ack, dram_ack;
    logic             irom_req, ir_we, dram_req, dram_we, rf_we, pc_we, commit, bus_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] inst_cnt;

    int unsigned      n_vec = 0;
    int unsigned      n_err = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_berr;

    multicycle_seq #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .run       (run),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .wb_ena    (wb_ena),
        .irom_ack  (irom_ack),
        .dram_ack  (dram_ack),
        .irom_req  (irom_req),
        .ir_we     (ir_we),
        .dram_req  (dram_req),
        .dram_we   (dram_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .commit    (commit),
        .state     (state),
        .inst_cnt  (inst_cnt),
        .bus_err   (bus_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive acks, sample mid-cycle, then step past the edge.
    // outs = {irom_req, ir_we, dram_req, dram_we, rf_we, pc_we, commit}
    task automatic cyc(input string tag, input logic ia, input logic da,
                       input logic [2:0] st, input logic [6:0] outs);
        irom_ack = ia;
        dram_ack = da;
        @(negedge cpu_clk);
        check({tag, "/state"}, 32'(state), 32'(st));
        check({tag, "/outs"}, 32'({irom_req, ir_we, dram_req, dram_we, rf_we, pc_we, commit}),
              32'(outs));
        check({tag, "/inst_cnt"}, 32'(inst_cnt), 32'(exp_cnt));
        check({tag, "/bus_err"}, 32'(bus_err), 32'(exp_berr));
        @(posedge cpu_clk);
        #1;
        irom_ack = 1'b0;
        dram_ack = 1'b0;
        if (outs[0]) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Transaction model of one instruction.
    // cls: 0 ALU, 1 branch, 2 no-writeback, 3 load, 4 store, 5 load+store (acts as load)
    // mode: 0 normal, 1 drop run at MEM, 2 reset at MEM, 3 DRAM never acks
    task automatic run_inst(input int cls, input int di, input int dm, input int mode);
        logic ld, st, br, wb, mem, stw, do_wb;
        ld = 1'b0; st = 1'b0; br = 1'b0; wb = 1'($urandom);
        case (cls)
            0: wb = 1'b1;
            1: br = 1'b1;
            2: wb = 1'b0;
            3: ld = 1'b1;
            4: st = 1'b1;
            default: begin ld = 1'b1; st = 1'b1; end
        endcase
        mem   = ld | st;
        stw   = st & ~ld;
        do_wb = ld | (~mem & ~br & wb);
        // Flags are junk until IR is stable in EX.
        is_load = 1'($urandom); is_store = 1'($urandom);
        is_branch = 1'($urandom); wb_ena = 1'($urandom);
        for (int k = 0; k < di; k++) cyc("if_wait", 1'b0, 1'b0, 3'd0, 7'b1000000);
        cyc("if_ack", 1'b1, 1'b0, 3'd0, 7'b1100000);
        cyc("id", 1'b0, 1'b0, 3'd1, 7'b0000000);
        is_load = ld; is_store = st; is_branch = br; wb_ena = wb;
        if (mem) cyc("ex_mem", 1'b0, 1'b0, 3'd2, 7'b0000000);
        else if (br || !wb) cyc("ex_commit", 1'b0, 1'b0, 3'd2, 7'b0000011);
        else cyc("ex_wb", 1'b0, 1'b0, 3'd2, 7'b0000000);
        if (mem) begin
            if (mode == 1) run = 1'b0;
            if (mode == 2) begin
                cpu_rst = 1'b1;
                cyc("rst_mem", 1'b0, 1'b1, 3'd3, 7'b0000000);
                cpu_rst = 1'b0;
                exp_cnt = '0;
                return;
            end
            if (mode == 3) begin
                for (int k = 0; k < int'(TMO); k++)
                    cyc("mem_tmo", 1'b0, 1'b0, 3'd3, {3'b001, stw, 3'b000});
                exp_berr = 1'b1;
                return;
            end
            for (int k = 0; k < dm; k++) cyc("mem_wait", 1'b0, 1'b0, 3'd3, {3'b001, stw, 3'b000});
            cyc("mem_ack", 1'b0, 1'b1, 3'd3, {3'b001, stw, 1'b0, stw, stw});
        end
        if (do_wb) cyc("wb", 1'b0, 1'b0, 3'd4, {4'b0000, wb, 2'b11});
    endtask

    initial begin
        cpu_rst = 1'b1; run = 1'b1; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
        wb_ena = 1'b0; irom_ack = 1'b0; dram_ack = 1'b0;
        exp_cnt = '0; exp_berr = 1'b0;
        @(posedge cpu_clk);
        #1;
        cyc("reset", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cpu_rst = 1'b0;

        // Directed: ADDI, ST with 2 waits, LD immediate, BEQ, then boundary ack delays.
        run_inst(0, 0, 0, 0);
        run_inst(4, 0, 2, 0);
        run_inst(3, 0, 0, 0);
        run_inst(1, 0, 0, 0);
        run_inst(5, TMO - 1, TMO - 1, 0);

        for (int i = 0; i < 40; i++)
            run_inst(int'($urandom_range(0, 5)), int'($urandom_range(0, TMO - 1)),
                     int'($urandom_range(0, TMO - 1)), 0);

        // run drops during MEM: retires, then parks.
        run_inst(3, 1, 2, 1);
        cyc("parked", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cyc("parked_ack", 1'b1, 1'b0, 3'd0, 7'b0000000);
        run = 1'b1;
        run_inst(0, 0, 0, 0);

        // Reset during MEM abandons the access.
        run_inst(4, 0, 0, 2);
        cyc("post_rst", 1'b0, 1'b0, 3'd0, 7'b1000000);
        run_inst(2, 0, 0, 0);

        // DRAM timeout.
        run_inst(4, 0, 0, 3);
        cyc("dram_tmo_park", 1'b1, 1'b0, 3'd0, 7'b0000000);
        cyc("dram_tmo_park", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cpu_rst = 1'b1;
        cyc("rst_berr", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cpu_rst = 1'b0;
        exp_berr = 1'b0;
        exp_cnt = '0;

        // IROM timeout, inst_cnt untouched.
        run_inst(0, 0, 0, 0);
        for (int k = 0; k < int'(TMO); k++) cyc("if_tmo", 1'b0, 1'b0, 3'd0, 7'b1000000);
        exp_berr = 1'b1;
        cyc("if_tmo_park", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cyc("if_tmo_park", 1'b1, 1'b0, 3'd0, 7'b0000000);
        cpu_rst = 1'b1;
        cyc("rst_final", 1'b0, 1'b0, 3'd0, 7'b0000000);
        cpu_rst = 1'b0;
        exp_berr = 1'b0;
        exp_cnt = '0;
        run_inst(3, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
